multi_debouncer: RTL and testbench
==================================

// Module: multi_debouncer
// PURPOSE
//  Parametrised N-channel debouncer for push-buttons and switches.
//  Each channel synchronises, polarity-normalises and debounces its input against a runtime-programmable stability count.
//  Per channel it emits one-cycle press, release and long-press (hold) pulses.
//  Sits between the board pins and control FSMs; replaces single-channel, fixed-count debouncing.
// PARAMETERS
//  CHANNELS     4   number of independent inputs
//  SYNC_STAGES  2   synchroniser depth per channel (min 2)
//  CNT_W        10  width of debounce counter and debounce_limit
//  HOLD_W       16  width of hold counter and hold_limit
//  ACTIVE_LOW   0   1: pin low = pressed; inversion applied after the synchroniser
// PORTS
//  clk             in   1         single clock, all logic rising-edge
//  rst             in   1         synchronous, active-high reset
//  btn_in          in   CHANNELS  raw asynchronous pin inputs
//  debounce_limit  in   CNT_W     stable cycles required to accept a change; 0 treated as 1
//  hold_limit      in   HOLD_W    pressed cycles before hold_pulse; 0 disables hold
//  btn_state       out  CHANNELS  debounced level, 1 = pressed
//  press_pulse     out  CHANNELS  1-cycle pulse on accepted 0->1
//  release_pulse   out  CHANNELS  1-cycle pulse on accepted 1->0
//  hold_pulse      out  CHANNELS  1-cycle pulse once per press at hold_limit
//  any_change      out  1         OR of press_pulse|release_pulse, same cycle
// BEHAVIOUR
//  Reset: sync flops load the inactive pin level (ACTIVE_LOW); btn_state, all pulses, any_change and counters are 0.
//  Reset applies at the next clk edge, mid-count or mid-press. No pulses are emitted on the reset edge or the edge after.
//  Sync: SYNC_STAGES flop chain per channel with no logic before stage 1. s = last stage XOR ACTIVE_LOW.
//  Debounce, per channel:
//   - s == btn_state: cnt <= 0.
//   - s != btn_state and cnt >= eff_limit-1 (eff_limit = max(debounce_limit,1)): btn_state <= s, cnt <= 0.
//   - s != btn_state otherwise: cnt <= cnt+1.
//   - A single agreeing cycle clears cnt. Glitches shorter than eff_limit cycles never propagate.
//  The >= compare makes a runtime decrease of debounce_limit below cnt fire on the next disagreeing cycle. cnt never wraps.
//  Latency, pin edge to btn_state: SYNC_STAGES + eff_limit cycles.
//  press_pulse/release_pulse are registered on the same edge that updates btn_state and are high for exactly 1 cycle.
//  Hold, per channel:
//   - hcnt clears when btn_state is 0 and on release.
//   - While btn_state is 1 and not yet fired: hcnt <= hcnt+1.
//   - When hcnt == hold_limit-1: hold_pulse for 1 cycle, fired flag set; hcnt stops and saturates.
//   - fired clears on release. hold_limit == 0: hold_pulse never asserts.
//   - A release on the same cycle as the hold threshold: release wins, no hold_pulse.
//  Channels are fully independent. Simultaneous events on multiple channels all pulse in the same cycle.
//  Outputs are registered. There is no combinational path from any input to any output.
// STRUCTURE
//  Shared package debounce_pkg holds:
//   - default parameter constants (DEF_CHANNELS, DEF_CNT_W, DEF_HOLD_W, DEF_SYNC_STAGES);
//   - an eff_limit helper function (0 -> 1).
//  One sub-module, debounce_channel, contains the synchroniser, debounce counter, hold logic and pulse flops for 1 bit.
//  multi_debouncer instantiates it CHANNELS times via generate and ORs the pulses into any_change.
// TESTING
//  1. rst=1 with btn_in=4'hF, ACTIVE_LOW=0 -> all outputs 0. Release rst -> btn_state=4'hF exactly 2+L cycles later, one press_pulse per channel.
//  2. debounce_limit=8, ch0 glitch high for 7 cycles -> no change. Glitch of 8 stable cycles -> press_pulse[0] at sync+8.
//  3. Bounce pattern (3 high, 1 low, repeat) for 100 cycles, then steady high -> exactly one press_pulse, only after the steady run.
//  4. hold_limit=20, press held 50 cycles -> single hold_pulse 20 cycles after press_pulse, then release_pulse. hold_limit=0 -> no hold_pulse.
//  5. debounce_limit changed 100->5 while cnt=30 -> btn_state flips on the next disagreeing cycle. debounce_limit=0 behaves as 1.
//  6. rst asserted mid-count and mid-hold -> counters, state and pulses 0 next edge. ch1 and ch3 pressed together -> pulses coincide, any_change=1 for 1 cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults and limit helper for the multi-channel debouncer
package debounce_pkg;

  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 10;
  localparam int DEF_HOLD_W      = 16;

  // A programmed limit of 0 behaves as 1 so a change always needs at least one stable cycle.
  function automatic int unsigned eff_limit(input int unsigned limit);
    return (limit == 0) ? 32'd1 : limit;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced input: synchroniser, stability counter, hold timer, pulses
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HOLD_W      = DEF_HOLD_W,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  input  logic [CNT_W-1:0]  debounce_limit,
  input  logic [HOLD_W-1:0] hold_limit,
  output logic              btn_state,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              hold_pulse
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hcnt;
  logic              fired;
  logic              s;
  logic              accept;

  assign s = sync[STAGES-1] ^ ACTIVE_LOW;

  // >= rather than == so lowering the limit below the running count fires immediately.
  always_comb begin
    accept = (s != btn_state) &&
             (32'(cnt) >= eff_limit(32'(debounce_limit)) - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync          <= {STAGES{ACTIVE_LOW}};
      btn_state     <= 1'b0;
      cnt           <= '0;
      hcnt          <= '0;
      fired         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
    end else begin
      sync          <= {sync[STAGES-2:0], btn};
      press_pulse   <= accept && s;
      release_pulse <= accept && !s;
      hold_pulse    <= 1'b0;

      if (accept) begin
        btn_state <= s;
        cnt       <= '0;
      end else if (s != btn_state) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end

      // accept while pressed is a release, which beats a coincident hold threshold
      if (!btn_state || accept) begin
        hcnt  <= '0;
        fired <= 1'b0;
      end else if (!fired) begin
        if (hold_limit != '0 && hcnt == hold_limit - HOLD_W'(1)) begin
          hold_pulse <= 1'b1;
          fired      <= 1'b1;
        end else if (hcnt != '1) begin
          hcnt <= hcnt + HOLD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N independent debounced inputs with press/release/hold pulses
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HOLD_W      = DEF_HOLD_W,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  input  logic [CNT_W-1:0]    debounce_limit,
  input  logic [HOLD_W-1:0]   hold_limit,
  output logic [CHANNELS-1:0] btn_state,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] hold_pulse,
  output logic                any_change
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .HOLD_W      (HOLD_W),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .clk            (clk),
      .rst            (rst),
      .btn            (btn_in[i]),
      .debounce_limit (debounce_limit),
      .hold_limit     (hold_limit),
      .btn_state      (btn_state[i]),
      .press_pulse    (press_pulse[i]),
      .release_pulse  (release_pulse[i]),
      .hold_pulse     (hold_pulse[i])
    );
  end

  // Reduction of registered pulses only, so no input reaches this output combinationally.
  assign any_change = |(press_pulse | release_pulse);

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - randomized and directed checks of multi_debouncer against a run-length model
module tb_multi_debouncer;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int CW = 10;
  localparam int HW = 16;
  localparam bit AL = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] btn_in;
  logic [CW-1:0] debounce_limit;
  logic [HW-1:0] hold_limit;
  logic [CH-1:0] btn_state, press_pulse, release_pulse, hold_pulse;
  logic          any_change;

  multi_debouncer #(
    .CHANNELS (CH), .SYNC_STAGES (SS), .CNT_W (CW), .HOLD_W (HW), .ACTIVE_LOW (AL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_in         (btn_in),
    .debounce_limit (debounce_limit),
    .hold_limit     (hold_limit),
    .btn_state      (btn_state),
    .press_pulse    (press_pulse),
    .release_pulse  (release_pulse),
    .hold_pulse     (hold_pulse),
    .any_change     (any_change)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: pin delay line, length of the current disagreeing run, cycles since press.
  bit            m_pipe [CH][SS];
  bit [CH-1:0]   m_state, m_press, m_rel, m_hold;
  int            m_run   [CH];
  int            m_since [CH];
  bit            m_fired [CH];

  function automatic void model_edge();
    for (int c = 0; c < CH; c++) begin
      bit s;
      bit acc;
      int eff;
      m_press[c] = 1'b0;
      m_rel[c]   = 1'b0;
      m_hold[c]  = 1'b0;
      if (rst) begin
        for (int i = 0; i < SS; i++) m_pipe[c][i] = AL;
        m_state[c] = 1'b0;
        m_run[c]   = 0;
        m_since[c] = 0;
        m_fired[c] = 1'b0;
      end else begin
        s = m_pipe[c][SS-1] ^ AL;
        for (int i = SS - 1; i > 0; i--) m_pipe[c][i] = m_pipe[c][i-1];
        m_pipe[c][0] = btn_in[c];
        eff = (debounce_limit == 0) ? 1 : int'(debounce_limit);
        acc = 1'b0;
        if (s != m_state[c]) begin
          m_run[c]++;
          if (m_run[c] >= eff) acc = 1'b1;
        end else begin
          m_run[c] = 0;
        end
        if (m_state[c] && !acc) begin
          m_since[c]++;
          if (!m_fired[c] && hold_limit != 0 && m_since[c] == int'(hold_limit)) begin
            m_hold[c]  = 1'b1;
            m_fired[c] = 1'b1;
          end
        end else begin
          m_since[c] = 0;
          m_fired[c] = 1'b0;
        end
        if (acc) begin
          m_state[c] = s;
          m_run[c]   = 0;
          m_press[c] = s;
          m_rel[c]   = !s;
        end
      end
    end
  endfunction

  int cyc;
  int full_at;
  int any_cycles;
  int press_cnt [CH], rel_cnt [CH], hold_cnt [CH];
  int first_press [CH], first_rel [CH], first_hold [CH];

  task automatic clear_acc();
    cyc        = 0;
    full_at    = -1;
    any_cycles = 0;
    for (int c = 0; c < CH; c++) begin
      press_cnt[c]   = 0;
      rel_cnt[c]     = 0;
      hold_cnt[c]    = 0;
      first_press[c] = -1;
      first_rel[c]   = -1;
      first_hold[c]  = -1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("btn_state",     32'(btn_state),     32'(m_state));
    check("press_pulse",   32'(press_pulse),   32'(m_press));
    check("release_pulse", 32'(release_pulse), 32'(m_rel));
    check("hold_pulse",    32'(hold_pulse),    32'(m_hold));
    check("any_change",    32'(any_change),    32'(|(m_press | m_rel)));
    cyc++;
    if (btn_state == 4'hF && full_at < 0) full_at = cyc;
    if (any_change) any_cycles++;
    for (int c = 0; c < CH; c++) begin
      if (press_pulse[c]) begin
        press_cnt[c]++;
        if (first_press[c] < 0) first_press[c] = cyc;
      end
      if (release_pulse[c]) begin
        rel_cnt[c]++;
        if (first_rel[c] < 0) first_rel[c] = cyc;
      end
      if (hold_pulse[c]) begin
        hold_cnt[c]++;
        if (first_hold[c] < 0) first_hold[c] = cyc;
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    btn_in         = 4'hF;
    debounce_limit = 10'd4;
    hold_limit     = 16'd0;
    clear_acc();

    // reset with all pins pressed, then release reset
    repeat (3) step();
    check("rst_state", 32'(btn_state), 32'h0);
    rst = 1'b0;
    clear_acc();
    repeat (12) step();
    check("lat_all", full_at, 6);
    for (int c = 0; c < CH; c++) check("press_once", press_cnt[c], 1);
    btn_in = 4'h0;
    repeat (15) step();

    // short glitch rejected, exact-length run accepted
    debounce_limit = 10'd8;
    clear_acc();
    btn_in = 4'b0001;
    repeat (7) step();
    btn_in = 4'b0000;
    repeat (20) step();
    check("glitch7", press_cnt[0], 0);
    clear_acc();
    btn_in = 4'b0001;
    repeat (8) step();
    btn_in = 4'b0000;
    repeat (20) step();
    check("glitch8_cnt", press_cnt[0], 1);
    check("glitch8_lat", first_press[0], 10);
    check("glitch8_rel", rel_cnt[0], 1);

    // bounce 3 high / 1 low, then steady
    clear_acc();
    for (int k = 0; k < 25; k++) begin
      btn_in = 4'b0001;
      repeat (3) step();
      btn_in = 4'b0000;
      step();
    end
    check("bounce_none", press_cnt[0], 0);
    clear_acc();
    btn_in = 4'b0001;
    repeat (30) step();
    check("bounce_steady", press_cnt[0], 1);
    check("bounce_lat", first_press[0], 10);
    btn_in = 4'b0000;
    repeat (20) step();

    // hold pulse, then hold disabled
    debounce_limit = 10'd4;
    hold_limit     = 16'd20;
    clear_acc();
    btn_in = 4'b0100;
    repeat (50) step();
    btn_in = 4'b0000;
    repeat (15) step();
    check("hold_once", hold_cnt[2], 1);
    check("hold_delay", first_hold[2] - first_press[2], 20);
    check("hold_rel", rel_cnt[2], 1);
    check("hold_before_rel", 32'(first_rel[2] > first_hold[2]), 32'h1);
    hold_limit = 16'd0;
    clear_acc();
    btn_in = 4'b0100;
    repeat (50) step();
    btn_in = 4'b0000;
    repeat (15) step();
    check("hold_off", hold_cnt[2], 0);
    check("hold_off_press", press_cnt[2], 1);

    // limit dropped mid-count, then limit 0 acts as 1
    debounce_limit = 10'd100;
    clear_acc();
    btn_in = 4'b1000;
    repeat (32) step();
    check("lim100_wait", 32'(btn_state[3]), 32'h0);
    debounce_limit = 10'd5;
    step();
    check("lim_drop", 32'(btn_state[3]), 32'h1);
    check("lim_drop_press", press_cnt[3], 1);
    debounce_limit = 10'd0;
    clear_acc();
    btn_in = 4'b0000;
    repeat (6) step();
    check("lim0_lat", first_rel[3], 3);

    // reset mid-hold and mid-count, then simultaneous presses
    debounce_limit = 10'd3;
    hold_limit     = 16'd40;
    btn_in = 4'b0001;
    repeat (12) step();
    btn_in = 4'b0101;
    repeat (2) step();
    rst = 1'b1;
    step();
    check("rst_mid_state", 32'(btn_state), 32'h0);
    check("rst_mid_pulse", 32'(press_pulse | release_pulse | hold_pulse), 32'h0);
    rst = 1'b0;
    btn_in = 4'b0000;
    repeat (10) step();
    clear_acc();
    btn_in = 4'b1010;
    repeat (12) step();
    check("dual_lat", first_press[1], 5);
    check("dual_coincide", first_press[3], first_press[1]);
    check("dual_any_once", any_cycles, 1);
    btn_in = 4'b0000;
    repeat (10) step();

    // randomized traffic with occasional reset
    for (int blk = 0; blk < 40; blk++) begin
      debounce_limit = CW'($urandom_range(0, 5));
      hold_limit     = HW'($urandom_range(0, 12));
      for (int k = 0; k < 50; k++) begin
        for (int c = 0; c < CH; c++)
          if ($urandom_range(0, 5) == 0) btn_in[c] = ~btn_in[c];
        rst = ($urandom_range(0, 199) == 0);
        step();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
